// File: rtl/servo_pwm_gen.sv
// ============================================================================
// servo_pwm_gen
//
// Servo PWM generator fed from the PWM duty register (r2[7:0]). A free-running
// frame counter defines a fixed period. Position commands are buffered and
// only take effect at a frame boundary, so every pulse is either the old
// width or the new width, never a runt or a stretched pulse.
//
// Ports:
//   clock       in   1  system clock, rising-edge active
//   ctrl_reset  in   1  synchronous active-high reset
//   cmd_we      in   1  one-cycle strobe qualifying cmd_pos
//   cmd_pos     in   8  requested position 0..255
//   enable      in   1  output enable, sampled at frame boundaries only
//   PWMout      out  1  registered servo pulse
//   frame_start out  1  registered one-cycle pulse on frame cycle 0
//   cmd_ack     out  1  one-cycle pulse when a command becomes active
//   cur_pos     out  8  position currently being driven
// ============================================================================
module servo_pwm_gen #(
    parameter int unsigned PERIOD_CYCLES = 500000,
    parameter int unsigned MIN_PULSE     = 25000,
    parameter int unsigned STEP_CYCLES   = 98,
    parameter int unsigned MAX_PULSE     = 50000,
    parameter int unsigned RESET_POS     = 128,
    parameter int unsigned CNT_W         = 19
) (
    input  logic       clock,
    input  logic       ctrl_reset,
    input  logic       cmd_we,
    input  logic [7:0] cmd_pos,
    input  logic       enable,
    output logic       PWMout,
    output logic       frame_start,
    output logic       cmd_ack,
    output logic [7:0] cur_pos
);

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [CNT_W:0]   wid_t;

    localparam cnt_t       LAST_CNT  = cnt_t'(PERIOD_CYCLES - 1);
    localparam logic [7:0] RESET_P8  = 8'(RESET_POS);

    // Pulse width for a position, saturated at MAX_PULSE. The product is
    // formed in 32 bits so an out-of-range position cannot wrap before the
    // clamp; after clamping the result always fits in CNT_W+1 bits because
    // MAX_PULSE < PERIOD_CYCLES <= 2^CNT_W.
    function automatic wid_t calc_width(input logic [7:0] pos);
        int unsigned full;
        full = MIN_PULSE + 32'(pos) * STEP_CYCLES;
        if (full > MAX_PULSE) full = MAX_PULSE;
        return wid_t'(full);
    endfunction

    cnt_t       cnt;
    logic       en_q;
    logic       pend_valid;
    logic [7:0] pend_pos;
    wid_t       width_act;

    logic       boundary;
    logic       apply;
    logic [7:0] apply_pos;
    cnt_t       cnt_next;
    logic       en_next;
    logic [7:0] pos_next;
    wid_t       width_next;

    // Next-state values; the output register compares against these so the
    // pulse edge lines up with the counter and width being loaded.
    always_comb begin
        boundary   = (cnt == LAST_CNT);
        cnt_next   = boundary ? '0 : cnt + cnt_t'(1);
        en_next    = boundary ? enable : en_q;
        // A write on the boundary cycle bypasses the pending buffer.
        apply      = boundary && (cmd_we || pend_valid);
        apply_pos  = cmd_we ? cmd_pos : pend_pos;
        pos_next   = apply ? apply_pos : cur_pos;
        width_next = apply ? calc_width(apply_pos) : width_act;
    end

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            cnt         <= '0;
            en_q        <= 1'b0;
            pend_valid  <= 1'b0;
            cur_pos     <= RESET_P8;
            width_act   <= calc_width(RESET_P8);
            PWMout      <= 1'b0;
            frame_start <= 1'b0;
            cmd_ack     <= 1'b0;
        end else begin
            cnt         <= cnt_next;
            en_q        <= en_next;
            cur_pos     <= pos_next;
            width_act   <= width_next;
            PWMout      <= en_next && ({1'b0, cnt_next} < width_next);
            frame_start <= (cnt_next == '0);
            cmd_ack     <= apply;
            if (boundary)
                pend_valid <= 1'b0;
            else if (cmd_we)
                pend_valid <= 1'b1;
        end
    end

    // Pending position is plain data; its validity is carried by pend_valid.
    always_ff @(posedge clock) begin
        if (cmd_we && !boundary)
            pend_pos <= cmd_pos;
    end

endmodule

// File: tb/tb_servo_pwm_gen.sv
module tb_servo_pwm_gen;

    localparam int P_CYC = 100;

    logic       clk = 1'b0;
    logic       ctrl_reset;
    logic       cmd_we;
    logic [7:0] cmd_pos;
    logic       enable;
    logic       PWMout;
    logic       frame_start;
    logic       cmd_ack;
    logic [7:0] cur_pos;

    int n_checks = 0;
    int n_err    = 0;

    servo_pwm_gen #(
        .PERIOD_CYCLES(100),
        .MIN_PULSE    (10),
        .STEP_CYCLES  (1),
        .MAX_PULSE    (90),
        .RESET_POS    (5),
        .CNT_W        (7)
    ) dut (
        .clock      (clk),
        .ctrl_reset (ctrl_reset),
        .cmd_we     (cmd_we),
        .cmd_pos    (cmd_pos),
        .enable     (enable),
        .PWMout     (PWMout),
        .frame_start(frame_start),
        .cmd_ack    (cmd_ack),
        .cur_pos    (cur_pos)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: frame position, list of writes seen in the current
    // frame, and the position / enable in force for the frame.
    // ------------------------------------------------------------------
    int   ph = 0;
    int   wq[$];
    bit   m_en = 0;
    int   m_pos = 5;
    bit   e_pwm = 0, e_fs = 0, e_ack = 0;
    bit   rst_seen = 0;

    // Frame statistics observed on the DUT outputs.
    int   k = 0, hi_cnt = 0, ack_cnt = 0, last_hi = -1, last_acks = -1;
    bit   contig = 1, last_contig = 0;

    function automatic int ref_width(input int p);
        int w;
        w = 10 + p * 1;
        if (w > 90) w = 90;
        return w;
    endfunction

    always @(posedge clk) begin
        rst_seen = ctrl_reset;
        if (ctrl_reset) begin
            ph = 0; wq.delete(); m_en = 0; m_pos = 5;
            e_pwm = 0; e_fs = 0; e_ack = 0;
        end else begin
            e_ack = 0;
            if (cmd_we) wq.push_back(int'(cmd_pos));
            if (ph == P_CYC - 1) begin
                ph   = 0;
                e_fs = 1;
                m_en = enable;
                if (wq.size() > 0) begin
                    m_pos = wq[$];
                    e_ack = 1;
                    wq.delete();
                end
            end else begin
                ph   = ph + 1;
                e_fs = 0;
            end
            e_pwm = m_en && (ph < ref_width(m_pos));
        end
        #1;
        if (rst_seen) begin
            k = 0; hi_cnt = 0; ack_cnt = 0; contig = 1;
        end else begin
            if (frame_start) begin
                last_hi = hi_cnt; last_acks = ack_cnt; last_contig = contig;
                k = 0; hi_cnt = 0; ack_cnt = 0; contig = 1;
            end
            if (PWMout) begin
                if (k != hi_cnt) contig = 0;
                hi_cnt++;
            end
            if (cmd_ack) ack_cnt++;
            k++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_fs(input string tag);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (frame_start) break;
        end
        if (!frame_start) begin
            n_checks++; n_err++;
            $display("FAIL %s: frame_start not seen within 300 cycles", tag);
        end
    endtask

    task automatic go_ph(input int p);
        for (int i = 0; i < 200 && ph != p; i++) @(negedge clk);
        if (ph != p) begin
            n_checks++; n_err++;
            $display("FAIL go_ph: phase %0d not reached (at %0d)", p, ph);
        end
    endtask

    task automatic test_reset();
        int cyc, early;
        repeat (3) @(negedge clk);
        n_checks++; if (PWMout !== 1'b0) begin n_err++; $display("FAIL reset_pwm: got %b want 0", PWMout); end
        n_checks++; if (frame_start !== 1'b0) begin n_err++; $display("FAIL reset_fs: got %b want 0", frame_start); end
        n_checks++; if (cmd_ack !== 1'b0) begin n_err++; $display("FAIL reset_ack: got %b want 0", cmd_ack); end
        n_checks++; if (cur_pos !== 8'd5) begin n_err++; $display("FAIL reset_pos: got %0d want 5", cur_pos); end
        ctrl_reset = 0;
        enable     = 1;
        cyc = 0; early = 0;
        while (cyc < 300 && frame_start !== 1'b1) begin
            @(negedge clk);
            cyc++;
            if (frame_start !== 1'b1 && (PWMout !== 1'b0 || cmd_ack !== 1'b0)) early++;
        end
        n_checks++; if (cyc != 100) begin n_err++; $display("FAIL first_fs_delay: got %0d want 100", cyc); end
        n_checks++; if (early != 0) begin n_err++; $display("FAIL pre_frame_activity: got %0d want 0", early); end
        n_checks++; if (PWMout !== 1'b1) begin n_err++; $display("FAIL pulse_with_fs: got %b want 1", PWMout); end
        wait_fs("idle_frame");
        n_checks++; if (last_hi != 15) begin n_err++; $display("FAIL idle_width: got %0d want 15", last_hi); end
        n_checks++; if (last_contig != 1) begin n_err++; $display("FAIL idle_contig: got %0d want 1", last_contig); end
        n_checks++; if (last_acks != 0) begin n_err++; $display("FAIL idle_acks: got %0d want 0", last_acks); end
        n_checks++; if (cur_pos !== 8'd5) begin n_err++; $display("FAIL idle_pos: got %0d want 5", cur_pos); end
    endtask

    task automatic test_single_cmd();
        go_ph(30);
        cmd_we = 1; cmd_pos = 8'd40;
        @(negedge clk);
        cmd_we = 0;
        n_checks++; if (cur_pos !== 8'd5) begin n_err++; $display("FAIL single_early_pos: got %0d want 5", cur_pos); end
        n_checks++; if (cmd_ack !== 1'b0) begin n_err++; $display("FAIL single_early_ack: got %b want 0", cmd_ack); end
        wait_fs("single_apply");
        n_checks++; if (cmd_ack !== 1'b1) begin n_err++; $display("FAIL single_ack: got %b want 1", cmd_ack); end
        n_checks++; if (cur_pos !== 8'd40) begin n_err++; $display("FAIL single_pos: got %0d want 40", cur_pos); end
        n_checks++; if (last_hi != 15) begin n_err++; $display("FAIL single_old_width: got %0d want 15", last_hi); end
        wait_fs("single_frame");
        n_checks++; if (last_hi != 50) begin n_err++; $display("FAIL single_new_width: got %0d want 50", last_hi); end
        n_checks++; if (last_acks != 1) begin n_err++; $display("FAIL single_acks: got %0d want 1", last_acks); end
    endtask

    task automatic test_multi_write();
        go_ph(10);
        cmd_we = 1; cmd_pos = 8'd20;
        @(negedge clk);
        cmd_we = 0;
        go_ph(50);
        cmd_we = 1; cmd_pos = 8'd60;
        @(negedge clk);
        cmd_we = 0;
        wait_fs("multi_apply");
        n_checks++; if (cmd_ack !== 1'b1) begin n_err++; $display("FAIL multi_ack: got %b want 1", cmd_ack); end
        n_checks++; if (cur_pos !== 8'd60) begin n_err++; $display("FAIL multi_pos: got %0d want 60", cur_pos); end
        n_checks++; if (last_acks != 0) begin n_err++; $display("FAIL multi_write_frame_acks: got %0d want 0", last_acks); end
        wait_fs("multi_frame");
        n_checks++; if (last_hi != 70) begin n_err++; $display("FAIL multi_width: got %0d want 70", last_hi); end
        n_checks++; if (last_acks != 1) begin n_err++; $display("FAIL multi_acks: got %0d want 1", last_acks); end
    endtask

    task automatic test_bypass();
        go_ph(99);
        cmd_we = 1; cmd_pos = 8'd0;
        @(negedge clk);
        cmd_we = 0;
        n_checks++; if (frame_start !== 1'b1) begin n_err++; $display("FAIL bypass_fs: got %b want 1", frame_start); end
        n_checks++; if (cmd_ack !== 1'b1) begin n_err++; $display("FAIL bypass_ack: got %b want 1", cmd_ack); end
        n_checks++; if (cur_pos !== 8'd0) begin n_err++; $display("FAIL bypass_pos: got %0d want 0", cur_pos); end
        wait_fs("bypass_frame");
        n_checks++; if (last_hi != 10) begin n_err++; $display("FAIL bypass_width: got %0d want 10", last_hi); end
        n_checks++; if (last_acks != 1) begin n_err++; $display("FAIL bypass_acks: got %0d want 1", last_acks); end
    endtask

    task automatic test_clamp_enable();
        go_ph(50);
        cmd_we = 1; cmd_pos = 8'd255;
        @(negedge clk);
        cmd_we = 0;
        wait_fs("clamp_apply");
        n_checks++; if (cur_pos !== 8'd255) begin n_err++; $display("FAIL clamp_pos: got %0d want 255", cur_pos); end
        go_ph(5);
        enable = 0;
        wait_fs("clamp_frame");
        n_checks++; if (last_hi != 90) begin n_err++; $display("FAIL clamp_width: got %0d want 90", last_hi); end
        n_checks++; if (last_contig != 1) begin n_err++; $display("FAIL clamp_contig: got %0d want 1", last_contig); end
        n_checks++; if (PWMout !== 1'b0) begin n_err++; $display("FAIL disabled_start: got %b want 0", PWMout); end
        // Re-enable mid-frame and queue a command while output is off.
        enable = 1;
        go_ph(20);
        cmd_we = 1; cmd_pos = 8'd40;
        @(negedge clk);
        cmd_we = 0;
        wait_fs("disabled_frame");
        n_checks++; if (last_hi != 0) begin n_err++; $display("FAIL disabled_width: got %0d want 0", last_hi); end
        n_checks++; if (cur_pos !== 8'd40) begin n_err++; $display("FAIL reenable_pos: got %0d want 40", cur_pos); end
        n_checks++; if (PWMout !== 1'b1) begin n_err++; $display("FAIL reenable_pwm: got %b want 1", PWMout); end
    endtask

    task automatic test_reset_mid();
        int cyc;
        go_ph(3);
        cmd_we = 1; cmd_pos = 8'd70;
        @(negedge clk);
        cmd_we = 0;
        go_ph(8);
        n_checks++; if (PWMout !== 1'b1) begin n_err++; $display("FAIL mid_in_pulse: got %b want 1", PWMout); end
        ctrl_reset = 1;
        @(negedge clk);
        ctrl_reset = 0;
        n_checks++; if (PWMout !== 1'b0) begin n_err++; $display("FAIL mid_reset_pwm: got %b want 0", PWMout); end
        n_checks++; if (cur_pos !== 8'd5) begin n_err++; $display("FAIL mid_reset_pos: got %0d want 5", cur_pos); end
        cyc = 0;
        while (cyc < 300 && frame_start !== 1'b1) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++; if (cyc != 100) begin n_err++; $display("FAIL mid_first_fs: got %0d want 100", cyc); end
        n_checks++; if (cmd_ack !== 1'b0) begin n_err++; $display("FAIL mid_discard_ack: got %b want 0", cmd_ack); end
        n_checks++; if (cur_pos !== 8'd5) begin n_err++; $display("FAIL mid_discard_pos: got %0d want 5", cur_pos); end
        wait_fs("mid_after");
        n_checks++; if (last_hi != 15) begin n_err++; $display("FAIL mid_after_width: got %0d want 15", last_hi); end
        n_checks++; if (last_acks != 0) begin n_err++; $display("FAIL mid_after_acks: got %0d want 0", last_acks); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            n_checks++; if (PWMout !== e_pwm) begin n_err++; $display("FAIL rand_pwm cyc %0d: got %b want %b", i, PWMout, e_pwm); end
            n_checks++; if (frame_start !== e_fs) begin n_err++; $display("FAIL rand_fs cyc %0d: got %b want %b", i, frame_start, e_fs); end
            n_checks++; if (cmd_ack !== e_ack) begin n_err++; $display("FAIL rand_ack cyc %0d: got %b want %b", i, cmd_ack, e_ack); end
            n_checks++; if (int'(cur_pos) != m_pos) begin n_err++; $display("FAIL rand_pos cyc %0d: got %0d want %0d", i, cur_pos, m_pos); end
            cmd_we  = ($urandom_range(0, 29) == 0);
            cmd_pos = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 149) == 0) enable = ~enable;
            ctrl_reset = ($urandom_range(0, 599) == 0);
        end
        cmd_we = 0;
        ctrl_reset = 0;
    endtask

    initial begin
        ctrl_reset = 1;
        cmd_we     = 0;
        cmd_pos    = 8'd0;
        enable     = 0;
        test_reset();
        test_single_cmd();
        test_multi_write();
        test_bypass();
        test_clamp_enable();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
